lif_cfg_driver: RTL

Upstream stimulus/configuration driver for the LIF neuron `top`. It accepts parallel 8-bit parameter words (`expd`, `w`, `t`) and synaptic stimulus requests over valid/ready handshakes. It serializes the parameters onto the neuron's bit-serial load interface (`set_vars`/`expd`/`w`/`t`) and generates `syn` pulses of programmable length. It sits between the host/test controller and `top`; its outputs connect 1:1 to `top`'s same-named inputs.

---
 rtl/lif_pkg.sv | 12 +
 rtl/lif_piso.sv | 30 +++
 rtl/lif_cfg_driver.sv | 101 ++++++++++
 3 files changed

// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared parameters and FSM state encodings for the LIF config driver
package lif_pkg;

    localparam int CFG_BITS   = 8;
    localparam int STIM_LEN_W = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_STIM   = 2'd3;

endpackage

// File: rtl/lif_piso.sv
// rtl/lif_piso.sv - parallel-in serial-out register, MSB first, zero-filling on shift
module lif_piso
    import lif_pkg::*;
#(
    parameter int W = CFG_BITS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] d,
    output logic         sout
);

    logic [W-1:0] q;

    // Zero fill means the serial output drops to 0 once every bit has left.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift) begin
            q <= {q[W-2:0], 1'b0};
        end
    end

    assign sout = q[W-1];

endmodule

// File: rtl/lif_cfg_driver.sv
// rtl/lif_cfg_driver.sv - serializes LIF parameter words and generates syn pulses
module lif_cfg_driver
    import lif_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CFG_BITS-1:0]   cfg_expd,
    input  logic [CFG_BITS-1:0]   cfg_w,
    input  logic [CFG_BITS-1:0]   cfg_t,
    input  logic                  stim_valid,
    output logic                  stim_ready,
    input  logic [STIM_LEN_W-1:0] stim_len,
    output logic                  set_vars,
    output logic                  expd,
    output logic                  w,
    output logic                  t,
    output logic                  syn,
    output logic                  busy
);

    localparam int CNT_W = $clog2(CFG_BITS);

    logic [1:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic [STIM_LEN_W-1:0] rem;
    logic                  cfg_fire;
    logic                  stim_fire;
    logic                  shifting;

    assign cfg_ready  = (state == ST_IDLE) && !rst;
    assign stim_ready = (state == ST_IDLE) && !rst && !cfg_valid;
    assign cfg_fire   = cfg_valid && cfg_ready;
    assign stim_fire  = stim_valid && stim_ready;
    assign shifting   = (state == ST_SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            rem      <= '0;
            set_vars <= 1'b0;
            syn      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cfg_fire) begin
                        state    <= ST_SHIFT;
                        cnt      <= '0;
                        set_vars <= 1'b1;
                        busy     <= 1'b1;
                    end else if (stim_fire && stim_len != '0) begin
                        state <= ST_STIM;
                        rem   <= stim_len - STIM_LEN_W'(1);
                        syn   <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(CFG_BITS - 1)) begin
                        state    <= ST_SETTLE;
                        set_vars <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                ST_STIM: begin
                    if (rem != '0) begin
                        rem <= rem - STIM_LEN_W'(1);
                    end else begin
                        state <= ST_IDLE;
                        syn   <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    lif_piso #(.W(CFG_BITS)) u_piso_expd (
        .clk(clk), .rst(rst), .load(cfg_fire), .shift(shifting), .d(cfg_expd), .sout(expd)
    );

    lif_piso #(.W(CFG_BITS)) u_piso_w (
        .clk(clk), .rst(rst), .load(cfg_fire), .shift(shifting), .d(cfg_w), .sout(w)
    );

    lif_piso #(.W(CFG_BITS)) u_piso_t (
        .clk(clk), .rst(rst), .load(cfg_fire), .shift(shifting), .d(cfg_t), .sout(t)
    );

endmodule
